line_buffer_ctrl: RTL and testbench
===================================

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_COLS, default 1600, maximum active pixels per line.
REQ-002 The block SHALL have parameter MAX_ROWS, default 900, maximum active lines per frame.
REQ-003 The block SHALL have parameter LAT, default 4, filter pipeline latency in clocks (range 1-16).
REQ-004 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- dv_i  in  1  input pixel valid.
- hs_i  in  1  input horizontal sync.
- vs_i  in  1  input vertical sync.
- wr_en_o  out  2  per-buffer write enable; bit0 = buffer 0, bit1 = buffer 1.
- wr_addr_o  out  11  line-buffer write address.
- rd_addr_o  out  11  shared read address for both buffers.
- prev_sel_o  out  1  buffer index holding row m-1; the other buffer holds row m.
- col_o  out  11  current column of the pixel on dv_i.
- row_o  out  10  current active row.
- win_valid_o  out  1  the 3x3 window centred at (row-1, col-1) is complete.
- border_o  out  1  the pixel is in the 1-pixel frame border and the filter output is forced to 0.
- dv_o  out  1  dv_i delayed by LAT.
- hs_o  out  1  hs_i delayed by LAT.
- vs_o  out  1  vs_i delayed by LAT.
- ovf_o  out  1  sticky line/frame overflow error.

Function
REQ-005 The FSM SHALL have three states: WAIT_VS, HBLANK and LINE.
REQ-006 The FSM SHALL make these transitions:
- WAIT_VS -> HBLANK on a vs_i rising edge.
- HBLANK -> LINE when dv_i=1.
- LINE -> HBLANK when dv_i=0.
- Any state -> HBLANK on a vs_i rising edge.
REQ-007 Edges SHALL be detected against a one-clock registered copy of each input.
REQ-008 A vs_i rising edge SHALL clear col, row and prev_sel to 0 and clear ovf_o, in the same cycle as the edge.
REQ-009 In LINE or HBLANK, each dv_i=1 cycle SHALL present the current col on col_o, and col SHALL then increment.
REQ-010 col SHALL saturate at MAX_COLS-1; a dv_i=1 cycle while col=MAX_COLS-1 SHALL set ovf_o.
REQ-011 On the LINE->HBLANK transition, col SHALL clear to 0, row SHALL increment, and prev_sel SHALL toggle.
REQ-012 row SHALL saturate at MAX_ROWS-1; a line ending while row=MAX_ROWS-1 SHALL set ovf_o.
REQ-013 hs_i SHALL affect only the sync delay line; line boundaries SHALL be derived from dv_i alone.
REQ-014 The write buffer SHALL be ~prev_sel.
REQ-015 wr_en_o SHALL assert only the write-buffer bit, in the cycle following each dv_i=1, with wr_addr_o equal to that pixel's col.
REQ-016 Whenever dv_i=1, rd_addr_o SHALL equal col combinationally, so BRAM data for both buffers arrives one clock later, aligned with wr_en_o.
REQ-017 win_valid_o SHALL be registered, and SHALL be 1 one clock after a dv_i=1 cycle with row>=2 and col>=2; otherwise 0.
REQ-018 border_o SHALL be registered with the same timing as win_valid_o, and SHALL be 1 when row<2 or col<2 on a dv_i=1 cycle.
REQ-019 In WAIT_VS, wr_en_o, win_valid_o and border_o SHALL be 0, and counters SHALL hold.
REQ-020 dv_o, hs_o and vs_o SHALL be an exact LAT-stage shift of dv_i, hs_i and vs_i, independent of FSM state.
REQ-021 If a vs_i edge and dv_i=1 occur in the same cycle, the vs_i edge SHALL win: the pixel SHALL be treated as col 0, row 0.
REQ-022 ovf_o SHALL remain set until rst or the next vs_i rising edge.

Reset
REQ-023 On rst, the FSM SHALL enter WAIT_VS.
REQ-024 On rst, col, row, prev_sel, wr_addr_o and rd_addr_o SHALL be 0.
REQ-025 On rst, wr_en_o, win_valid_o, border_o and ovf_o SHALL be 0.
REQ-026 On rst, all LAT delay stages and the edge-detect registers SHALL be 0.
REQ-027 rst asserted mid-line SHALL discard the line; the first frame after reset SHALL begin only at a vs_i rising edge.

Structure
REQ-028 MAX_COLS, MAX_ROWS, the address/row widths and the FSM state encoding SHALL reside in shared package fir_pkg.
REQ-029 The LAT sync delay SHALL be a separate sub-module, sync_delay, parameterised by stage count, and reused by the filter top.
REQ-030 line_buffer_ctrl SHALL NOT instantiate the BRAMs; it SHALL only drive their ports.

Verification
REQ-031 Scenario 1: rst, vs pulse, then 4 lines of 8 dv pixels with 4-clock gaps -> wr_en_o alternates 01/10 per line, wr_addr_o runs 0..7, row_o ends at 4.
REQ-032 Scenario 2: same stimulus -> win_valid_o asserts only for row 2-3, col 2-7 (12 pulses per frame); border_o covers the remaining 20 pixels.
REQ-033 Scenario 3: MAX_COLS=8, line of 10 pixels -> col_o sticks at 7, ovf_o=1 from the 9th pixel, ovf_o cleared by the next vs edge.
REQ-034 Scenario 4: vs_i edge coincident with dv_i=1 mid-line -> that pixel reports col 0, row 0, prev_sel_o=0.
REQ-035 Scenario 5: LAT=4, random dv/hs/vs pattern -> dv_o/hs_o/vs_o equal the inputs delayed exactly 4 clocks.
REQ-036 Scenario 6: rst mid-line, then dv pixels without vs -> no wr_en_o or win_valid_o until a vs_i rising edge.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, frame limits and line-buffer FSM encoding
package fir_pkg;

    localparam int COL_W        = 11;
    localparam int ROW_W        = 10;
    localparam int DEF_MAX_COLS = 1600;
    localparam int DEF_MAX_ROWS = 900;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        HBLANK  = 2'd1,
        LINE    = 2'd2
    } lb_state_t;

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth shift register that keeps sync/valid aligned with the filter pipeline
module sync_delay #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - ping-pong line-buffer addressing, 3x3 window/border flags and sync delay
module line_buffer_ctrl
    import fir_pkg::*;
#(
    parameter int MAX_COLS = DEF_MAX_COLS,
    parameter int MAX_ROWS = DEF_MAX_ROWS,
    parameter int LAT      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dv_i,
    input  logic             hs_i,
    input  logic             vs_i,
    output logic [1:0]       wr_en_o,
    output logic [COL_W-1:0] wr_addr_o,
    output logic [COL_W-1:0] rd_addr_o,
    output logic             prev_sel_o,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             win_valid_o,
    output logic             border_o,
    output logic             dv_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             ovf_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAX_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAX_ROWS - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    lb_state_t        state_q, state_d;
    logic             vs_q;
    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic             prev_sel_q, prev_sel_d, prev_sel_cur;
    logic             ovf_q, ovf_d, ovf_cur;
    logic             vs_rise, px, line_end;
    logic [2:0]       sync_q;

    assign vs_rise  = vs_i & ~vs_q;
    assign px       = dv_i & (vs_rise | (state_q != WAIT_VS));
    assign line_end = (state_q == LINE) & ~dv_i & ~vs_rise;

    // A frame start overrides stored position so a coincident pixel lands at (0,0)
    assign col_cur      = vs_rise ? '0 : col_q;
    assign row_cur      = vs_rise ? '0 : row_q;
    assign prev_sel_cur = vs_rise ? 1'b0 : prev_sel_q;
    assign ovf_cur      = vs_rise ? 1'b0 : ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_VS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            state_d = HBLANK;
        end else begin
            case (state_q)
                HBLANK:  if (dv_i)  state_d = LINE;
                LINE:    if (!dv_i) state_d = HBLANK;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        col_d      = col_cur;
        row_d      = row_cur;
        prev_sel_d = prev_sel_cur;
        ovf_d      = ovf_cur;
        if (px) begin
            if (col_cur == COL_LAST) ovf_d = 1'b1;
            else                     col_d = col_cur + COL_W'(1);
        end
        if (line_end) begin
            col_d      = '0;
            prev_sel_d = ~prev_sel_cur;
            if (row_cur == ROW_LAST) ovf_d = 1'b1;
            else                     row_d = row_cur + ROW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q        <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            prev_sel_q  <= 1'b0;
            ovf_q       <= 1'b0;
            wr_en_o     <= 2'b00;
            wr_addr_o   <= '0;
            win_valid_o <= 1'b0;
            border_o    <= 1'b0;
        end else begin
            vs_q        <= vs_i;
            col_q       <= col_d;
            row_q       <= row_d;
            prev_sel_q  <= prev_sel_d;
            ovf_q       <= ovf_d;
            // Write lands one clock later, alongside BRAM read data for this column
            wr_en_o     <= px ? (prev_sel_cur ? 2'b01 : 2'b10) : 2'b00;
            if (px) wr_addr_o <= col_cur;
            win_valid_o <= px & (row_cur >= ROW_TWO) & (col_cur >= COL_TWO);
            border_o    <= px & ((row_cur < ROW_TWO) | (col_cur < COL_TWO));
        end
    end

    assign col_o      = col_cur;
    assign row_o      = row_cur;
    assign rd_addr_o  = col_cur;
    assign prev_sel_o = prev_sel_cur;
    assign ovf_o      = ovf_cur;

    sync_delay #(
        .STAGES (LAT),
        .WIDTH  (3)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .d   ({vs_i, hs_i, dv_i}),
        .q   (sync_q)
    );

    assign {vs_o, hs_o, dv_o} = sync_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb/tb_line_buffer_ctrl.sv - self-checking bench for line_buffer_ctrl against a pixel/line index model
module tb_line_buffer_ctrl;

    localparam int LAT     = 4;
    localparam int SM_COLS = 8;
    localparam int SM_ROWS = 4;

    logic clk = 1'b0;
    logic rst, dv_i, hs_i, vs_i;

    logic [1:0]  m_wr_en_o, s_wr_en_o;
    logic [10:0] m_wr_addr_o, s_wr_addr_o, m_rd_addr_o, s_rd_addr_o, m_col_o, s_col_o;
    logic [9:0]  m_row_o, s_row_o;
    logic        m_prev_sel_o, s_prev_sel_o, m_win_valid_o, s_win_valid_o;
    logic        m_border_o, s_border_o, m_ovf_o, s_ovf_o;
    logic        m_dv_o, m_hs_o, m_vs_o, s_dv_o, s_hs_o, s_vs_o;

    always #5 clk = ~clk;

    line_buffer_ctrl #(.LAT(LAT)) u_main (
        .clk(clk), .rst(rst), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .wr_en_o(m_wr_en_o), .wr_addr_o(m_wr_addr_o), .rd_addr_o(m_rd_addr_o),
        .prev_sel_o(m_prev_sel_o), .col_o(m_col_o), .row_o(m_row_o),
        .win_valid_o(m_win_valid_o), .border_o(m_border_o),
        .dv_o(m_dv_o), .hs_o(m_hs_o), .vs_o(m_vs_o), .ovf_o(m_ovf_o)
    );

    line_buffer_ctrl #(.MAX_COLS(SM_COLS), .MAX_ROWS(SM_ROWS), .LAT(LAT)) u_small (
        .clk(clk), .rst(rst), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .wr_en_o(s_wr_en_o), .wr_addr_o(s_wr_addr_o), .rd_addr_o(s_rd_addr_o),
        .prev_sel_o(s_prev_sel_o), .col_o(s_col_o), .row_o(s_row_o),
        .win_valid_o(s_win_valid_o), .border_o(s_border_o),
        .dv_o(s_dv_o), .hs_o(s_hs_o), .vs_o(s_vs_o), .ovf_o(s_ovf_o)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0] hist[$];
    bit         vs_prev, ovf_s, chk_func;
    logic [1:0] p_wr_en, ps_wr_en;
    int         p_addr, ps_addr;
    bit         p_win, p_bord, ps_win, ps_bord;
    int         win_cnt, bord_cnt;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_pend();
        p_wr_en = 2'b00; p_win = 1'b0; p_bord = 1'b0;
        ps_wr_en = 2'b00; ps_win = 1'b0; ps_bord = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_wr_en", m_wr_en_o, 0);
        chk("rst_win", m_win_valid_o, 0);
        chk("rst_border", m_border_o, 0);
        chk("rst_ovf", m_ovf_o, 0);
        chk("rst_col", m_col_o, 0);
        chk("rst_row", m_row_o, 0);
        chk("rst_prev_sel", m_prev_sel_o, 0);
        chk("rst_wr_addr", m_wr_addr_o, 0);
        chk("rst_rd_addr", m_rd_addr_o, 0);
        chk("rst_sync", {m_vs_o, m_hs_o, m_dv_o}, 0);
        chk("rst_s_ovf", s_ovf_o, 0);
        hist.delete();
        for (int i = 0; i <= LAT; i++) hist.push_back(3'b000);
        vs_prev = 1'b0;
        ovf_s = 1'b0;
        clear_pend();
    endtask

    // k: pixel index within line L (-1 when no pixel should be accepted); le marks the cycle a line ends
    task automatic step(input bit dv, input bit hs, input bit vs, input int k, input int L, input bit le);
        bit rise;
        logic [2:0] e3;
        int cs, rs;
        @(posedge clk); #1;
        dv_i = dv; hs_i = hs; vs_i = vs;
        hist.push_back({vs, hs, dv});
        #1;
        rise = vs && !vs_prev;
        vs_prev = vs;
        e3 = hist[hist.size() - 1 - LAT];
        chk("sync_delay", {m_vs_o, m_hs_o, m_dv_o}, e3);
        chk("s_sync_delay", {s_vs_o, s_hs_o, s_dv_o}, e3);
        if (chk_func) begin
            chk("wr_en", m_wr_en_o, p_wr_en);
            chk("win_valid", m_win_valid_o, p_win);
            chk("border", m_border_o, p_bord);
            if (p_wr_en != 2'b00) chk("wr_addr", m_wr_addr_o, p_addr);
            chk("s_wr_en", s_wr_en_o, ps_wr_en);
            chk("s_win_valid", s_win_valid_o, ps_win);
            chk("s_border", s_border_o, ps_bord);
            if (ps_wr_en != 2'b00) chk("s_wr_addr", s_wr_addr_o, ps_addr);
            win_cnt += int'(m_win_valid_o);
            bord_cnt += int'(m_border_o);
            chk("ovf", m_ovf_o, 0);
            if (rise) ovf_s = 1'b0;
            chk("s_ovf", s_ovf_o, ovf_s);
            clear_pend();
            if (k >= 0) begin
                cs = imin(k, SM_COLS - 1);
                rs = imin(L, SM_ROWS - 1);
                chk("col", m_col_o, k);
                chk("row", m_row_o, L);
                chk("prev_sel", m_prev_sel_o, L % 2);
                chk("rd_addr", m_rd_addr_o, k);
                chk("s_col", s_col_o, cs);
                chk("s_row", s_row_o, rs);
                chk("s_prev_sel", s_prev_sel_o, L % 2);
                chk("s_rd_addr", s_rd_addr_o, cs);
                p_wr_en  = (L % 2 == 1) ? 2'b01 : 2'b10;
                ps_wr_en = p_wr_en;
                p_addr   = k;
                ps_addr  = cs;
                p_win    = (L >= 2) && (k >= 2);
                p_bord   = !p_win;
                ps_win   = (rs >= 2) && (cs >= 2);
                ps_bord  = !ps_win;
                if (cs == SM_COLS - 1) ovf_s = 1'b1;
            end
            if (le && imin(L, SM_ROWS - 1) == SM_ROWS - 1) ovf_s = 1'b1;
        end
    endtask

    task automatic vs_pulse();
        step(1'b0, 1'($urandom_range(0, 1)), 1'b1, -1, 0, 1'b0);
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, -1, 0, 1'b0);
    endtask

    task automatic run_line(input int L, input int len, input int gap, input bit vs_first);
        for (int k = 0; k < len; k++)
            step(1'b1, 1'($urandom_range(0, 1)), vs_first && (k == 0), k, L, 1'b0);
        for (int g = 0; g < gap; g++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, -1, L, g == 0);
    endtask

    task automatic run_frame(input int nlines, input int len, input int gap, input bit rnd);
        vs_pulse();
        for (int L = 0; L < nlines; L++)
            run_line(L, rnd ? int'($urandom_range(2, 12)) : len, rnd ? int'($urandom_range(1, 4)) : gap, 1'b0);
    endtask

    initial begin
        rst = 1'b1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        chk_func = 1'b1;
        win_cnt = 0; bord_cnt = 0;
        reset_dut();

        // Pixels before any frame start are ignored
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, -1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, -1, 0, 1'b0);

        // Four 8-pixel lines: ping-pong writes, window/border split, small instance saturates
        win_cnt = 0; bord_cnt = 0;
        run_frame(4, 8, 4, 1'b0);
        chk("row_end", m_row_o, 4);
        chk("s_row_end", s_row_o, SM_ROWS - 1);
        chk("win_pulses", win_cnt, 12);
        chk("border_pulses", bord_cnt, 20);

        // 10-pixel line into an 8-column instance
        run_frame(1, 10, 3, 1'b0);
        chk("s_ovf_sticky", s_ovf_o, 1);
        vs_pulse();

        repeat (3) run_frame(int'($urandom_range(1, 6)), 0, 0, 1'b1);

        // Frame start coincident with a pixel in the middle of a line
        vs_pulse();
        run_line(0, 6, 2, 1'b0);
        run_line(1, 5, 3, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, k, 2, 1'b0);
        run_line(0, 5, 2, 1'b1);
        run_line(1, 4, 2, 1'b0);

        // Random sync pattern: only the delay line is checked
        chk_func = 1'b0;
        repeat (200) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0, 1'b0);
        chk_func = 1'b1;
        reset_dut();

        // Reset mid-line, then pixels without a frame start
        vs_pulse();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, k, 0, 1'b0);
        reset_dut();
        for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, -1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
        run_frame(2, 5, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
